uop_queue: RTL and testbench

UOP_QUEUE -- requirements
Module: uop_queue

---
 rtl/decode_pkg.sv | 26 ++
 rtl/uop_queue_if.sv | 31 +++
 rtl/uop_queue.sv | 78 +++++++
 tb/tb_uop_queue.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode-stage types: the decoded micro-op record, fetch epoch width,
// uop queue depth and the serialization predicate used by the queue and dispatch.
package decode_pkg;

  localparam int FETCH_EPOCH_W = 3;
  localparam int UOPQ_DEPTH    = 8;

  typedef struct packed {
    logic                     valid;
    logic [31:0]              pc;
    logic [FETCH_EPOCH_W-1:0] fetch_epoch;
    logic [6:0]               opcode;
    logic [4:0]               rd;
    logic                     is_csr;
    logic                     is_fence;
    logic                     is_ecall;
    logic                     is_ebreak;
    logic                     is_mret;
  } uop_t;

  // A serializing uop may only leave decode once the backend has drained.
  function automatic logic is_serializing(input uop_t u);
    return u.is_csr | u.is_fence | u.is_ecall | u.is_ebreak | u.is_mret;
  endfunction

endpackage

// File: rtl/uop_queue_if.sv
// Bundle of the decoder-to-dispatch uop queue signals; master is the side that
// feeds the queue and drains it, slave is the queue itself.
interface uop_queue_if
  import decode_pkg::*;
#(
  parameter int DEPTH = UOPQ_DEPTH
);

  logic                       enq_valid;
  uop_t                       enq_uop;
  logic                       enq_ready;
  logic [FETCH_EPOCH_W-1:0]   cur_epoch;
  logic                       deq_valid;
  uop_t                       deq_uop;
  logic                       deq_ready;
  logic                       flush;
  logic                       backend_empty;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       drop;

  modport master (
    output enq_valid, enq_uop, cur_epoch, deq_ready, flush, backend_empty,
    input  enq_ready, deq_valid, deq_uop, count, drop
  );

  modport slave (
    input  enq_valid, enq_uop, cur_epoch, deq_ready, flush, backend_empty,
    output enq_ready, deq_valid, deq_uop, count, drop
  );

endinterface

// File: rtl/uop_queue.sv
// Decoded-uop FIFO between decode and rename/dispatch. Drops stale-epoch uops at
// entry and holds serializing uops at the head until the backend is empty.
module uop_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = UOPQ_DEPTH  // power of two, >= 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enq_valid_i,
  input  uop_t                       enq_uop_i,
  output logic                       enq_ready_o,
  input  logic [FETCH_EPOCH_W-1:0]   cur_epoch_i,
  output logic                       deq_valid_o,
  output uop_t                       deq_uop_o,
  input  logic                       deq_ready_i,
  input  logic                       flush_i,
  input  logic                       backend_empty_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       drop_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and enq_ready ignores deq_ready.

  uop_t          mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic full;
  logic enq_fire;
  logic epoch_ok;
  logic wr_en;
  logic deq_fire;
  uop_t head_uop;

  assign full        = (count == CW'(DEPTH));
  assign enq_ready_o = !full && !flush_i;
  assign enq_fire    = enq_valid_i && enq_ready_o && !rst_i;
  assign epoch_ok    = (enq_uop_i.fetch_epoch == cur_epoch_i);
  assign wr_en       = enq_fire && enq_uop_i.valid && epoch_ok;
  assign drop_o      = enq_fire && enq_uop_i.valid && !epoch_ok;

  assign head_uop    = mem[head];
  assign deq_uop_o   = head_uop;
  assign deq_valid_o = !rst_i && (count != '0) && !flush_i &&
                       !(is_serializing(head_uop) && !backend_empty_i);
  assign deq_fire    = deq_valid_o && deq_ready_i;
  assign count_o     = count;

  // Payload storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[tail] <= enq_uop_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        tail <= tail + PW'(1);
      end
      if (deq_fire) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(wr_en) - CW'(deq_fire);
    end
  end

endmodule

// File: tb/tb_uop_queue.sv
// Randomised and directed bench for uop_queue: a driver feeds a queue-based
// reference model, a negedge monitor compares every DUT output against it.
module tb_uop_queue;
  import decode_pkg::*;

  localparam int DEPTH = 8;
  localparam int UW    = $bits(uop_t);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uop_queue_if #(.DEPTH(DEPTH)) qif ();

  uop_queue #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enq_valid_i    (qif.enq_valid),
    .enq_uop_i      (qif.enq_uop),
    .enq_ready_o    (qif.enq_ready),
    .cur_epoch_i    (qif.cur_epoch),
    .deq_valid_o    (qif.deq_valid),
    .deq_uop_o      (qif.deq_uop),
    .deq_ready_i    (qif.deq_ready),
    .flush_i        (qif.flush),
    .backend_empty_i(qif.backend_empty),
    .count_o        (qif.count),
    .drop_o         (qif.drop)
  );

  // Reference model: the ordered list of uops that should be sitting in the queue.
  logic [UW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit needs_drain(input uop_t u);
    return (u.is_csr || u.is_fence || u.is_ecall || u.is_ebreak || u.is_mret);
  endfunction

  function automatic uop_t mk_uop(input logic [31:0] pc, input logic [FETCH_EPOCH_W-1:0] ep,
                                  input logic v, input logic csr);
    uop_t u;
    u = '0;
    u.valid = v;
    u.pc = pc;
    u.fetch_epoch = ep;
    u.opcode = csr ? 7'h73 : 7'h13;
    u.rd = pc[6:2];
    u.is_csr = csr;
    return u;
  endfunction

  // One clock of stimulus; the model gains the uop after the edge if it was written.
  task automatic step(input logic ev, input uop_t u, input logic dr, input logic fl,
                      input logic be, input logic rs);
    bit will_write;
    qif.enq_valid = ev;
    qif.enq_uop = u;
    qif.deq_ready = dr;
    qif.flush = fl;
    qif.backend_empty = be;
    rst = rs;
    will_write = ev && !fl && !rs && (exp_q.size() < DEPTH) && u.valid &&
                 (u.fetch_epoch == qif.cur_epoch);
    @(posedge clk);
    #1;
    if (rs || fl) exp_q.delete();
    else if (will_write) exp_q.push_back(UW'(u));
  endtask

  task automatic idle(input int n, input logic dr, input logic be);
    for (int i = 0; i < n; i++) step(1'b0, '0, dr, 1'b0, be, 1'b0);
  endtask

  // Monitor: outputs are stable at the falling edge; a predicted dequeue pops the model.
  always @(negedge clk) begin
    if (mon_en) begin
      uop_t hd;
      bit rdy_exp, val_exp, drop_exp;
      hd = (exp_q.size() != 0) ? uop_t'(exp_q[0]) : uop_t'('0);
      rdy_exp  = (exp_q.size() < DEPTH) && !qif.flush;
      val_exp  = !rst && (exp_q.size() != 0) && !qif.flush &&
                 !(needs_drain(hd) && !qif.backend_empty);
      drop_exp = !rst && qif.enq_valid && rdy_exp && qif.enq_uop.valid &&
                 (qif.enq_uop.fetch_epoch != qif.cur_epoch);
      check("count", 64'(qif.count), 64'(exp_q.size()));
      check("enq_ready", 64'(qif.enq_ready), 64'(rdy_exp));
      check("deq_valid", 64'(qif.deq_valid), 64'(val_exp));
      check("drop", 64'(qif.drop), 64'(drop_exp));
      if (val_exp && qif.deq_ready) begin
        check("deq_uop", 64'(qif.deq_uop), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    uop_t u;
    logic [31:0] pc;
    qif.enq_valid = 1'b0;
    qif.enq_uop = '0;
    qif.cur_epoch = '0;
    qif.deq_ready = 1'b0;
    qif.flush = 1'b0;
    qif.backend_empty = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Fill with deq_ready low, then drain in pc order.
    for (int k = 0; k < 8; k++)
      step(1'b1, mk_uop(32'h8000_0000 + 32'(4 * k), '0, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b1);
    idle(10, 1'b1, 1'b1);

    // Stale epoch and invalid uop: handshake completes, nothing is stored.
    qif.cur_epoch = 3'd3;
    step(1'b1, mk_uop(32'h100, 3'd2, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, mk_uop(32'h104, 3'd3, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b1);

    // Serializing head blocks while the backend is busy; enqueues keep going.
    step(1'b1, mk_uop(32'h200, 3'd3, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 6; k++)
      step(1'b1, mk_uop(32'h200 + 32'(4 * k), 3'd3, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(8, 1'b1, 1'b1);

    // Flush at count 5 together with an enqueue and a dequeue.
    for (int k = 0; k < 5; k++)
      step(1'b1, mk_uop(32'h300 + 32'(4 * k), 3'd3, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, mk_uop(32'hdead_0000, 3'd3, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);

    // Wrap the tail, fill, then dequeue at full while enq_valid is held.
    for (int k = 0; k < 3; k++)
      step(1'b1, mk_uop(32'h400 + 32'(4 * k), 3'd3, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++)
      step(1'b1, mk_uop(32'h500 + 32'(4 * k), 3'd3, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, mk_uop(32'h5f0, 3'd3, 1'b1, 1'b0), 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, mk_uop(32'h5f4, 3'd3, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10, 1'b1, 1'b1);

    // Reset in the middle of operation at count 4.
    for (int k = 0; k < 4; k++)
      step(1'b1, mk_uop(32'h600 + 32'(4 * k), 3'd3, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, mk_uop(32'h610, 3'd3, 1'b1, 1'b0), 1'b1, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      logic fl, rs;
      pc = $urandom;
      fl = ($urandom_range(0, 49) == 0);
      rs = ($urandom_range(0, 149) == 0);
      u = mk_uop(pc, ($urandom_range(0, 7) == 0) ? qif.cur_epoch + 3'd1 : qif.cur_epoch,
                 ($urandom_range(0, 15) != 0), ($urandom_range(0, 11) == 0));
      u.is_fence = ($urandom_range(0, 29) == 0);
      u.is_mret  = ($urandom_range(0, 59) == 0);
      step(1'($urandom_range(0, 3) != 0), u, 1'($urandom_range(0, 2) != 0), fl,
           1'($urandom_range(0, 2) != 0), rs);
      if (fl) qif.cur_epoch = qif.cur_epoch + 3'd1;
    end
    idle(12, 1'b1, 1'b1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
